// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues 1-cycle-latency i_cache reads and buffers
// returned instructions in a 2-entry skid FIFO feeding decode through a valid/ready handshake.
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] ic_rd_dest,
  output logic        ic_rd_en,
  output logic        ic_nop,
  input  logic [15:0] ic_rd_out,
  input  logic [15:0] ic_pc_out,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_instr,
  output logic [15:0] dec_pc
);

  logic [15:0] r_pc;
  logic        r_inflight;
  logic [1:0]  r_count;
  logic        r_head;
  logic [15:0] r_instr [2];
  logic [15:0] r_ipc   [2];

  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic        w_tail;
  logic [2:0]  w_credit;

  assign w_valid  = !rst && (r_count != 2'd0);
  assign w_pop    = w_valid && dec_ready;
  // Slots already committed after this edge: buffered + in flight - leaving now.
  assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_push   = r_inflight && !br_taken && !rst;
  assign w_tail   = r_head ^ r_count[0];

  assign ic_rd_dest = r_pc;
  assign ic_nop     = rst | br_taken;
  assign ic_rd_en   = !rst && !br_taken && (w_credit < 3'(FIFO_DEPTH));

  assign dec_valid = w_valid;
  assign dec_instr = w_valid ? r_instr[r_head] : 16'h0000;
  assign dec_pc    = w_valid ? r_ipc[r_head] : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
    end else if (br_taken) begin
      r_pc       <= br_target;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
    end else begin
      if (ic_rd_en) begin
        r_pc <= r_pc + 16'd1;
      end
      r_inflight <= ic_rd_en;
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[w_tail] <= ic_rd_out;
      r_ipc[w_tail]   <= ic_pc_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && (r_count == 2'(FIFO_DEPTH))));
    end
  end

endmodule
